vram_access_arbiter: RTL and testbench

Shares one single-port character/tile video RAM between the VGA scan-out path and up to NUM_CLIENTS sale-terminal UI writers. Scan-out reads are scheduled from the sync generator's raster counters and are never delayed. Client accesses are served round-robin in the remaining cycles through a req/gnt handshake. The block sits between the HV sync generator, the UI update logic and the VRAM macro, and feeds the character/pixel pipeline.

---
 rtl/vram_access_arbiter.sv | 132 +++++++++++++
 tb/tb_vram_access_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_access_arbiter.sv
// rtl/vram_access_arbiter.sv - VRAM port sharing: fixed scan-out slots plus round-robin UI clients
module vram_access_arbiter #(
  parameter int CNTR_WIDTH_H = 11,
  parameter int CNTR_WIDTH_V = 10,
  parameter int NUM_CLIENTS  = 4,
  parameter int ADDR_WIDTH   = 13,
  parameter int DATA_WIDTH   = 8,
  parameter int COLS         = 100,
  parameter int ROWS         = 75
) (
  input  logic                              VGA_CLK,
  input  logic                              RESET_N,
  input  logic [CNTR_WIDTH_H-1:0]           counter_x,
  input  logic [CNTR_WIDTH_V-1:0]           counter_y,
  input  logic [NUM_CLIENTS-1:0]            cli_req,
  input  logic [NUM_CLIENTS-1:0]            cli_we,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cli_addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cli_wdata,
  output logic [NUM_CLIENTS-1:0]            cli_gnt,
  output logic [NUM_CLIENTS-1:0]            cli_rvalid,
  output logic [DATA_WIDTH-1:0]             cli_rdata,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic                              mem_we,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  output logic [DATA_WIDTH-1:0]             scan_data,
  output logic                              scan_valid
);

  localparam int PTR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int H_VIS = COLS * 8;
  localparam int V_VIS = ROWS * 8;

  logic [PTR_W-1:0]       rr_ptr;
  logic [NUM_CLIENTS-1:0] eligible, upper, hi_req, sel_onehot;
  logic [PTR_W-1:0]       hi_idx, lo_idx, sel_idx, next_ptr;
  logic                   hi_any, lo_any, grant, scan_slot, sel_we;
  logic [ADDR_WIDTH-1:0]  scan_addr, sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;

  logic                   t1_valid, t1_scan, t2_valid, t2_scan;
  logic [PTR_W-1:0]       t1_idx, t2_idx;

  always_comb begin
    scan_slot = (counter_x[2:0] == 3'd0) &&
                (counter_x < CNTR_WIDTH_H'(H_VIS)) &&
                (counter_y < CNTR_WIDTH_V'(V_VIS));
    scan_addr = ADDR_WIDTH'(counter_y >> 3) * ADDR_WIDTH'(COLS) + ADDR_WIDTH'(counter_x >> 3);

    // Last cycle's grantee is masked so it cannot win again before it sees cli_gnt.
    eligible = cli_req & ~cli_gnt;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      upper[k] = (PTR_W'(k) >= rr_ptr);
    end
    hi_req = eligible & upper;
    hi_any = |hi_req;
    lo_any = |eligible;
    hi_idx = '0;
    lo_idx = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      if (hi_req[k])   hi_idx = PTR_W'(k);
      if (eligible[k]) lo_idx = PTR_W'(k);
    end
    sel_idx  = hi_any ? hi_idx : lo_idx;
    grant    = !scan_slot && lo_any;
    next_ptr = (sel_idx == PTR_W'(NUM_CLIENTS - 1)) ? '0 : sel_idx + 1'b1;

    sel_onehot = '0;
    sel_addr   = '0;
    sel_wdata  = '0;
    sel_we     = 1'b0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (PTR_W'(k) == sel_idx) begin
        sel_onehot[k] = grant;
        sel_addr      = cli_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata     = cli_wdata[k*DATA_WIDTH +: DATA_WIDTH];
        sel_we        = cli_we[k];
      end
    end
  end

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rr_ptr     <= '0;
      cli_gnt    <= '0;
      cli_rvalid <= '0;
      cli_rdata  <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      scan_data  <= '0;
      scan_valid <= 1'b0;
      t1_valid   <= 1'b0;
      t1_scan    <= 1'b0;
      t1_idx     <= '0;
      t2_valid   <= 1'b0;
      t2_scan    <= 1'b0;
      t2_idx     <= '0;
    end else begin
      cli_gnt  <= sel_onehot;
      mem_we   <= 1'b0;
      t1_valid <= 1'b0;
      t1_scan  <= 1'b0;
      t1_idx   <= sel_idx;
      if (scan_slot) begin
        mem_addr <= scan_addr;
        t1_valid <= 1'b1;
        t1_scan  <= 1'b1;
      end else if (grant) begin
        mem_addr  <= sel_addr;
        mem_we    <= sel_we;
        mem_wdata <= sel_wdata;
        t1_valid  <= !sel_we;
        rr_ptr    <= next_ptr;
      end

      t2_valid <= t1_valid;
      t2_scan  <= t1_scan;
      t2_idx   <= t1_idx;

      // mem_rdata belongs to the access tagged in stage 2.
      scan_valid <= t2_valid && t2_scan;
      if (t2_valid && t2_scan) scan_data <= mem_rdata;
      cli_rvalid <= '0;
      if (t2_valid && !t2_scan) begin
        cli_rvalid <= NUM_CLIENTS'(1) << t2_idx;
        cli_rdata  <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vram_access_arbiter.sv
// tb/tb_vram_access_arbiter.sv - directed bench for vram_access_arbiter with a behavioural VRAM
module tb_vram_access_arbiter;

  logic        VGA_CLK;
  logic        RESET_N;
  logic [10:0] counter_x;
  logic [9:0]  counter_y;
  logic [3:0]  cli_req, cli_we;
  logic [51:0] cli_addr;
  logic [31:0] cli_wdata;
  logic [3:0]  cli_gnt, cli_rvalid;
  logic [7:0]  cli_rdata;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata, mem_rdata, scan_data;
  logic        scan_valid;

  int errors = 0;
  int checks = 0;

  vram_access_arbiter dut (
    .VGA_CLK(VGA_CLK), .RESET_N(RESET_N),
    .counter_x(counter_x), .counter_y(counter_y),
    .cli_req(cli_req), .cli_we(cli_we), .cli_addr(cli_addr), .cli_wdata(cli_wdata),
    .cli_gnt(cli_gnt), .cli_rvalid(cli_rvalid), .cli_rdata(cli_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .scan_data(scan_data), .scan_valid(scan_valid)
  );

  initial VGA_CLK = 1'b0;
  always #5 VGA_CLK = ~VGA_CLK;

  // Synchronous single-port VRAM preloaded with ram[i] = i[7:0] ^ 8'hA5.
  logic [7:0] ram [0:8191];
  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = 8'(i) ^ 8'hA5;
    mem_rdata = 8'h00;
  end
  always @(posedge VGA_CLK) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge VGA_CLK);
    #1;
  endtask

  task automatic set_cli(input int k, input logic we, input logic [12:0] a, input logic [7:0] d);
    cli_we[k] = we;
    cli_addr[k*13 +: 13] = a;
    cli_wdata[k*8 +: 8] = d;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"},    32'(cli_gnt), 0);
    chk({tag, "_rvalid"}, 32'(cli_rvalid), 0);
    chk({tag, "_rdata"},  32'(cli_rdata), 0);
    chk({tag, "_maddr"},  32'(mem_addr), 0);
    chk({tag, "_mwe"},    32'(mem_we), 0);
    chk({tag, "_mwdata"}, 32'(mem_wdata), 0);
    chk({tag, "_sdata"},  32'(scan_data), 0);
    chk({tag, "_svalid"}, 32'(scan_valid), 0);
  endtask

  typedef struct {
    logic [10:0] cx;
    logic [9:0]  cy;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [12:0] addr;
    logic [7:0]  wdata;
    logic [12:0] e_addr;
    logic        e_we;
    logic [3:0]  e_gnt;
    logic        e_sv;
    logic [7:0]  e_sd;
    logic [3:0]  e_rv;
    logic [7:0]  e_rd;
  } vec_t;

  vec_t tbl [11];
  logic [3:0] prev_gnt;
  int last_g [4];

  initial begin
    tbl[0]  = '{11'd16,   10'd9,   4'b0000, 4'b0000, 13'd0,    8'h00, 13'd102,  1'b0, 4'b0000, 1'b1, 8'hC3, 4'b0000, 8'h00};
    tbl[1]  = '{11'd800,  10'd9,   4'b0000, 4'b0000, 13'd0,    8'h00, 13'd102,  1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 8'h00};
    tbl[2]  = '{11'd0,    10'd600, 4'b0000, 4'b0000, 13'd0,    8'h00, 13'd102,  1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 8'h00};
    tbl[3]  = '{11'd792,  10'd599, 4'b0000, 4'b0000, 13'd0,    8'h00, 13'd7499, 1'b0, 4'b0000, 1'b1, 8'hEE, 4'b0000, 8'h00};
    tbl[4]  = '{11'd17,   10'd0,   4'b0000, 4'b0000, 13'd0,    8'h00, 13'd7499, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 8'h00};
    tbl[5]  = '{11'd0,    10'd0,   4'b0000, 4'b0000, 13'd0,    8'h00, 13'd0,    1'b0, 4'b0000, 1'b1, 8'hA5, 4'b0000, 8'h00};
    tbl[6]  = '{11'd801,  10'd0,   4'b1000, 4'b1000, 13'h123,  8'h77, 13'h123,  1'b1, 4'b1000, 1'b0, 8'h00, 4'b0000, 8'h00};
    tbl[7]  = '{11'd801,  10'd0,   4'b0100, 4'b0000, 13'h123,  8'h00, 13'h123,  1'b0, 4'b0100, 1'b0, 8'h00, 4'b0100, 8'h77};
    tbl[8]  = '{11'd24,   10'd15,  4'b0000, 4'b0000, 13'd0,    8'h00, 13'd103,  1'b0, 4'b0000, 1'b1, 8'hC2, 4'b0000, 8'h00};
    tbl[9]  = '{11'd1000, 10'd700, 4'b0000, 4'b0000, 13'd0,    8'h00, 13'd103,  1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 8'h00};
    tbl[10] = '{11'd801,  10'd0,   4'b0001, 4'b0000, 13'd7499, 8'h00, 13'd7499, 1'b0, 4'b0001, 1'b0, 8'h00, 4'b0001, 8'hEE};

    RESET_N = 1'b0;
    counter_x = 11'd801; counter_y = 10'd0;
    cli_req = '0; cli_we = '0; cli_addr = '0; cli_wdata = '0;
    tick(); tick();
    chk_zero("reset");
    RESET_N = 1'b1;
    tick();

    // Table: one decision cycle per vector, then two idle cycles to the return stage.
    for (int i = 0; i < 11; i++) begin
      counter_x = tbl[i].cx; counter_y = tbl[i].cy;
      for (int k = 0; k < 4; k++) set_cli(k, tbl[i].we[k], tbl[i].addr, tbl[i].wdata);
      cli_req = tbl[i].req;
      tick();
      chk($sformatf("v%0d_maddr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("v%0d_mwe", i),   32'(mem_we),   32'(tbl[i].e_we));
      chk($sformatf("v%0d_gnt", i),   32'(cli_gnt),  32'(tbl[i].e_gnt));
      if (tbl[i].e_we) chk($sformatf("v%0d_mwdata", i), 32'(mem_wdata), 32'(tbl[i].wdata));
      cli_req = '0; counter_x = 11'd801; counter_y = 10'd0;
      tick(); tick();
      chk($sformatf("v%0d_svalid", i), 32'(scan_valid), 32'(tbl[i].e_sv));
      chk($sformatf("v%0d_rvalid", i), 32'(cli_rvalid), 32'(tbl[i].e_rv));
      if (tbl[i].e_sv) chk($sformatf("v%0d_sdata", i), 32'(scan_data), 32'(tbl[i].e_sd));
      if (tbl[i].e_rv != 0) chk($sformatf("v%0d_rdata", i), 32'(cli_rdata), 32'(tbl[i].e_rd));
    end

    // Client 1 write collides with a scan slot and is deferred by one cycle.
    counter_x = 11'd0; counter_y = 10'd0;
    set_cli(1, 1'b1, 13'd5, 8'h41);
    cli_req = 4'b0010;
    tick();
    chk("a_slot_gnt", 32'(cli_gnt), 0);
    chk("a_slot_addr", 32'(mem_addr), 0);
    chk("a_slot_we", 32'(mem_we), 0);
    counter_x = 11'd1;
    tick();
    chk("a_gnt1", 32'(cli_gnt), 32'h2);
    chk("a_waddr", 32'(mem_addr), 5);
    chk("a_we", 32'(mem_we), 1);
    chk("a_wdata", 32'(mem_wdata), 32'h41);
    cli_req = 4'b0001; counter_x = 11'd2;
    set_cli(0, 1'b0, 13'd5, 8'h00);
    tick();
    chk("a_gnt0", 32'(cli_gnt), 32'h1);
    chk("a_raddr", 32'(mem_addr), 5);
    cli_req = '0; counter_x = 11'd3;
    tick();
    chk("a_rvalid_early", 32'(cli_rvalid), 0);
    tick();
    chk("a_rvalid", 32'(cli_rvalid), 32'h1);
    chk("a_rdata", 32'(cli_rdata), 32'h41);
    tick();
    chk("a_rvalid_pulse", 32'(cli_rvalid), 0);
    chk("a_rdata_hold", 32'(cli_rdata), 32'h41);

    // Reset while client 2's read is in flight.
    counter_x = 11'd801;
    set_cli(2, 1'b0, 13'd9, 8'h00);
    cli_req = 4'b0100;
    tick();
    chk("r_gnt_pre", 32'(cli_gnt), 32'h4);
    RESET_N = 1'b0;
    #1;
    chk_zero("r_async");
    tick();
    chk("r_rvalid_a", 32'(cli_rvalid), 0);
    tick();
    chk("r_rvalid_b", 32'(cli_rvalid), 0);
    RESET_N = 1'b1;
    tick();
    chk("r_gnt_after", 32'(cli_gnt), 32'h4);
    chk("r_rvalid_c", 32'(cli_rvalid), 0);
    cli_req = '0;
    tick(); tick(); tick();
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;

    // All four requesting continuously in blanking: strict 0,1,2,3 rotation.
    for (int k = 0; k < 4; k++) begin
      set_cli(k, 1'b0, 13'(k + 20), 8'h00);
      last_g[k] = -1;
    end
    cli_req = 4'b1111;
    prev_gnt = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("b_gnt%0d", i), 32'(cli_gnt), 32'(4'b0001 << (i % 4)));
      chk($sformatf("b_norepeat%0d", i), 32'(cli_gnt & prev_gnt), 0);
      for (int k = 0; k < 4; k++) begin
        if (cli_gnt[k]) begin
          if (last_g[k] >= 0) chk($sformatf("b_wait%0d", k), 32'((i - last_g[k]) <= 5), 1);
          last_g[k] = i;
        end
      end
      prev_gnt = cli_gnt;
    end
    cli_req = '0;
    tick(); tick(); tick();

    // Single client holding req: grants only on alternate cycles.
    set_cli(3, 1'b1, 13'd50, 8'h99);
    cli_req = 4'b1000;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("c_gnt%0d", i), 32'(cli_gnt), (i % 2 == 0) ? 32'h8 : 32'h0);
      chk($sformatf("c_we%0d", i), 32'(mem_we), (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    cli_req = '0;
    tick(); tick();

    // Client 1 withdraws during a scan slot: no access and no pointer movement.
    counter_x = 11'd8; counter_y = 10'd0;
    set_cli(1, 1'b1, 13'd77, 8'h55);
    cli_req = 4'b0010;
    tick();
    chk("d_slot_gnt", 32'(cli_gnt), 0);
    chk("d_slot_addr", 32'(mem_addr), 1);
    cli_req = '0; counter_x = 11'd9;
    tick();
    chk("d_gnt", 32'(cli_gnt), 0);
    chk("d_we", 32'(mem_we), 0);
    chk("d_addr_hold", 32'(mem_addr), 1);
    set_cli(0, 1'b0, 13'd30, 8'h00);
    set_cli(2, 1'b0, 13'd31, 8'h00);
    cli_req = 4'b0101; counter_x = 11'd10;
    tick();
    chk("d_rr_gnt", 32'(cli_gnt), 32'h1);
    chk("d_rr_addr", 32'(mem_addr), 30);
    cli_req = '0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
